// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state and operation encodings for the serial add/sub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: DIGIT-wide ripple slice; cmsb is the carry into the slice MSB
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] cy;
  assign cy[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (.a(x[i]), .b(y[i]), .ci(cy[i]), .s(s[i]), .co(cy[i+1]));
  end
  assign cout = cy[DIGIT];
  assign cmsb = cy[DIGIT-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement add/sub; ADDSUB_SAT_EN enables saturation on overflow
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] s;
  logic             cout, cmsb;
  logic             last;
  assign last = idx == IW'(NDIG - 1);
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x(ra[idx*DIGIT +: DIGIT]),
    .y(rb[idx*DIGIT +: DIGIT]),
    .cin(carry),
    .s(s),
    .cout(cout),
    .cmsb(cmsb)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b ^ {WIDTH{m}};
          carry    <= m == OP_SUB;
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          r[idx*DIGIT +: DIGIT] <= s;
          carry <= cout;
          idx   <= idx + IW'(1);
          if (last) begin
            c <= cout;
            v <= cmsb ^ cout;
`ifdef ADDSUB_SAT_EN
            if (cmsb ^ cout) r <= ra[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed self-checking bench for addsub_serial (DIGIT=4 and DIGIT=16 instances)
module tb_addsub_serial;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, out_ready = 0, m = 0;
  logic [15:0] a = 0, b = 0;
  logic        in_ready, out_valid, c, v;
  logic [15:0] r;
  logic        w_in_valid = 0, w_out_ready = 0, w_m = 0;
  logic [15:0] w_a = 0, w_b = 0;
  logic        w_in_ready, w_out_valid, w_c, w_v;
  logic [15:0] w_r;
  int tests = 0, fails = 0;
`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] OVF_ADD_R = 16'h7FFF, OVF_SUB_R = 16'h8000;
`else
  localparam logic [15:0] OVF_ADD_R = 16'h8000, OVF_SUB_R = 16'h7FFF;
`endif
  always #5 clk = ~clk;
  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .c(c), .v(v)
  );
  addsub_serial #(.WIDTH(16), .DIGIT(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b), .m(w_m),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .r(w_r), .c(w_c), .v(w_v)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [15:0] ta, input logic [15:0] tb_, input logic tm);
    a = ta; b = tb_; m = tm; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    int n;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    check({tag, "_lat"}, n, 4);
  endtask
  task automatic release_out(input string tag);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                    input logic [15:0] er, input logic ec, input logic ev);
    start(ta, tb_, tm);
    wait_done(tag);
    check({tag, "_r"}, r, er);
    check({tag, "_c"}, c, ec);
    check({tag, "_v"}, v, ev);
    release_out(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rcv", {r, c, v}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    op("add", 16'h1234, 16'h0FF0, 0, 16'h2224, 0, 0);
    op("sub_borrow", 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
    op("sub_noborrow", 16'h0007, 16'h0005, 1, 16'h0002, 1, 0);
    op("ovf_add", 16'h7FFF, 16'h0001, 0, OVF_ADD_R, 0, 1);
    op("ovf_sub", 16'h8000, 16'h0001, 1, OVF_SUB_R, 1, 1);
    check("idle_hold_r", r, OVF_SUB_R);
    start(16'h00F0, 16'h000F, 0);
    wait_done("bp");
    a = 16'h1111; b = 16'h2222; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_ov", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_rcv", {r, c, v}, {16'h00FF, 1'b0, 1'b0});
    end
    in_valid = 0;
    release_out("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_accept", out_valid, 0);
    start(16'h1234, 16'h4321, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_r", r, 0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", out_valid, 0);
    op("wrap", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    w_a = 16'hABCD; w_b = 16'h1111; w_m = 0; w_in_valid = 1;
    @(posedge clk); #1;
    w_in_valid = 0;
    check("wide_not_yet", w_out_valid, 0);
    @(posedge clk); #1;
    check("wide_ov", w_out_valid, 1);
    check("wide_rcv", {w_r, w_c, w_v}, {16'hBCDE, 1'b0, 1'b0});
    w_out_ready = 1;
    @(posedge clk); #1;
    w_out_ready = 0;
    check("wide_in_ready", w_in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
